// File: rtl/coincidence_count_reporter.sv
// coincidence_count_reporter: gated per-channel pulse counter that snapshots counts at window end and streams them as a byte frame
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   pulse_in[NCH]    single-cycle event pulses, one per channel
//   enable           1 runs gate windows, 0 holds timer and live counts at 0
//   tx_data/valid    frame byte stream (HDR, status, counts MSB first)
//   tx_ready         downstream accept
//   window_done      pulse the cycle after each window end
//   frame_drop       pulse when a window end is discarded because a frame is in flight
module coincidence_count_reporter #(
    parameter int          NCH           = 4,
    parameter int          CNT_W         = 16,
    parameter int          WINDOW_CYCLES = 100000000,
    parameter logic [7:0]  HDR           = 8'hA5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] pulse_in,
    input  logic           enable,
    output logic [7:0]     tx_data,
    output logic           tx_valid,
    input  logic           tx_ready,
    output logic           window_done,
    output logic           frame_drop
);
    localparam int NB = CNT_W / 8;
    localparam int FL = 2 + NCH * NB;
    localparam int TW = $clog2(WINDOW_CYCLES);
    localparam int IW = $clog2(FL);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [TW-1:0]    timer;
    logic [CNT_W-1:0] live   [NCH];
    logic [CNT_W-1:0] nxt    [NCH];
    logic [CNT_W-1:0] shadow [NCH];
    logic [NCH-1:0]   sat, ovf, status;
    logic [8*FL-1:0]  frame;
    logic [7:0]       nbyte;
    logic [0:0]       state;
    logic [IW-1:0]    idx, nidx;
    logic             snap, clr, last;

    assign snap = enable && timer == TW'(WINDOW_CYCLES - 1);
    assign clr  = !enable || snap;
    assign nidx = idx + 1'b1;
    assign last = idx == IW'(FL - 1);

    // Saturating increment; an attempt at max flags overflow instead of wrapping
    genvar i;
    for (i = 0; i < NCH; i++) begin : g_ch
        assign ovf[i] = pulse_in[i] & (&live[i]);
        assign nxt[i] = live[i] + CNT_W'(pulse_in[i] & ~ovf[i]);
    end

    // Whole frame laid out MSB-first so byte k sits at the top after shifting left by k bytes
    always_comb begin
        frame = '0;
        frame[8*FL-1 -: 8] = HDR;
        frame[8*FL-16 +: NCH] = status;
        for (int k = 0; k < NCH; k++)
            frame[8*(FL-2)-1-k*CNT_W -: CNT_W] = shadow[k];
        nbyte = 8'(frame >> (8 * (FL - 1 - int'(nidx))));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer       <= '0;
            sat         <= '0;
            status      <= '0;
            state       <= IDLE;
            idx         <= '0;
            tx_valid    <= 1'b0;
            tx_data     <= '0;
            window_done <= 1'b0;
            frame_drop  <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                live[k]   <= '0;
                shadow[k] <= '0;
            end
        end else begin
            timer       <= clr ? '0 : timer + 1'b1;
            sat         <= clr ? '0 : sat | ovf;
            window_done <= snap;
            frame_drop  <= snap && state == SEND;
            for (int k = 0; k < NCH; k++)
                live[k] <= clr ? '0 : nxt[k];
            if (state == IDLE) begin
                if (snap) begin
                    for (int k = 0; k < NCH; k++)
                        shadow[k] <= nxt[k];
                    status   <= sat | ovf;
                    state    <= SEND;
                    idx      <= '0;
                    tx_valid <= 1'b1;
                    tx_data  <= HDR;
                end
            end else if (tx_ready) begin
                if (last) begin
                    state    <= IDLE;
                    tx_valid <= 1'b0;
                end else begin
                    idx     <= nidx;
                    tx_data <= nbyte;
                end
            end
        end
    end
endmodule
